// File: rtl/pipe_ripple_adder_pkg.sv
// Shared constants for the pipelined ripple-carry adder: default geometry
// and the widths of the fields carried in each stage record.
package pipe_ripple_adder_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_STAGES = 4;

  localparam int CARRY_W = 1;
  localparam int VLD_W   = 1;

  function automatic int seg_w(input int width, input int stages);
    return width / stages;
  endfunction

  // Stage record: operand a, effective operand b, partial sum, carry, valid.
  function automatic int rec_w(input int width);
    return 3 * width + CARRY_W + VLD_W;
  endfunction

endpackage

// File: rtl/pipe_ripple_adder_if.sv
// Operand/result handshake bundle for pipe_ripple_adder; master drives
// operands and consumes results, slave is the adder.
interface pipe_ripple_adder_if
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             zero;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf, zero
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf, zero
  );

endinterface

// File: rtl/pipe_ripple_adder_seg_adder.sv
// Combinational SEG-bit adder slice with carry-in and carry-out.
module seg_adder #(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SEG{1'b0}}, ci};
  assign s     = total[SEG-1:0];
  assign co    = total[SEG];

endmodule

// File: rtl/pipe_ripple_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit slice per stage,
// carry handed forward through the stage registers, global stall on backpressure.
module pipe_ripple_adder
  import pipe_ripple_adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pipe_ripple_adder_if.slave   bus
);

  localparam int SEG  = seg_w(WIDTH, STAGES);
  localparam int LAST = STAGES - 1;

  if ((WIDTH % STAGES) != 0) begin : g_bad_split
    $error("pipe_ripple_adder: WIDTH must be an exact multiple of STAGES");
  end
  if (WIDTH < 2 || WIDTH > 128) begin : g_bad_width
    $error("pipe_ripple_adder: WIDTH must be within 2..128");
  end

  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

  logic en;

  // Per-stage view of the operation entering the slice this cycle.
  logic [WIDTH-1:0] a_in   [STAGES];
  logic [WIDTH-1:0] b_in   [STAGES];
  logic [WIDTH-1:0] s_in   [STAGES];
  logic             c_in   [STAGES];
  logic             v_in   [STAGES];
  logic [SEG-1:0]   seg_s  [STAGES];
  logic             seg_c  [STAGES];
  logic [WIDTH-1:0] sum_nx [STAGES];

  logic [WIDTH-1:0] a_p    [STAGES];
  logic [WIDTH-1:0] b_p    [STAGES];
  logic [WIDTH-1:0] sum_p  [STAGES];
  logic             c_p    [STAGES];
  logic             vld_p  [STAGES];
  logic             ovf_p;
  logic             zero_p;

  logic ovf_nx;
  logic zero_nx;

  assign en          = !vld_p[LAST] || bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_first
      // Subtract folds into add of ~b with a forced carry-in of 1.
      assign a_in[k] = bus.a;
      assign b_in[k] = bus.sub ? ~bus.b : bus.b;
      assign c_in[k] = bus.sub | bus.cin;
      assign s_in[k] = '0;
      assign v_in[k] = bus.in_valid;
    end else begin : g_next
      assign a_in[k] = a_p[k-1];
      assign b_in[k] = b_p[k-1];
      assign c_in[k] = c_p[k-1];
      assign s_in[k] = sum_p[k-1];
      assign v_in[k] = vld_p[k-1];
    end

    seg_adder #(.SEG(SEG)) u_seg (
      .a  (a_in[k][k*SEG +: SEG]),
      .b  (b_in[k][k*SEG +: SEG]),
      .ci (c_in[k]),
      .s  (seg_s[k]),
      .co (seg_c[k])
    );

    assign sum_nx[k] = s_in[k] | (WIDTH'(seg_s[k]) << (k * SEG));
  end

  assign ovf_nx  = signed_ovf(a_in[LAST][WIDTH-1], b_in[LAST][WIDTH-1],
                              sum_nx[LAST][WIDTH-1]);
  assign zero_nx = (sum_nx[LAST] == '0);

  // Stage registers: data path, advanced only on the global enable.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int k = 0; k < STAGES; k++) begin
        a_p[k]   <= a_in[k];
        b_p[k]   <= b_in[k];
        sum_p[k] <= sum_nx[k];
        c_p[k]   <= seg_c[k];
      end
      ovf_p  <= ovf_nx;
      zero_p <= zero_nx;
    end
  end

  // Stage registers: valid bits, cleared asynchronously so in-flight work is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
    end else if (en) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= v_in[k];
    end
  end

  // Result fields are masked by valid so they read 0 in reset and for bubbles.
  assign bus.out_valid = vld_p[LAST];
  assign bus.sum       = vld_p[LAST] ? sum_p[LAST] : '0;
  assign bus.cout      = vld_p[LAST] & c_p[LAST];
  assign bus.ovf       = vld_p[LAST] & ovf_p;
  assign bus.zero      = vld_p[LAST] & zero_p;

endmodule

// File: tb/tb_pipe_ripple_adder.sv
// Directed bench for pipe_ripple_adder (WIDTH=8, STAGES=4): vector table,
// back-to-back stream, random stream, backpressure stall and mid-flight reset.
module tb_pipe_ripple_adder;

  localparam int W = 8;
  localparam int S = 4;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] s;
    logic       co;
    logic       ov;
    logic       z;
  } vec_t;

  typedef struct {
    logic [10:0] res;
    int          acc;
    bit          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  vec_t vecs[10];

  pipe_ripple_adder_if #(.WIDTH(W)) bus ();

  pipe_ripple_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic cin, input logic sub);
    int sa, sb, sr;
    logic [7:0] s;
    logic co, ov;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      s  = a - b;
      co = (a >= b);
      sr = sa - sb;
    end else begin
      s  = a + b + {7'd0, cin};
      co = ((int'(a) + int'(b) + int'(cin)) > 255);
      sr = sa + sb + int'(cin);
    end
    ov = (sr > 127) || (sr < -128);
    return {s, co, ov, (s == 8'h00)};
  endfunction

  function automatic logic [31:0] out_word();
    return {21'd0, bus.sum, bus.cout, bus.ovf, bus.zero};
  endfunction

  // Result monitor: every delivered result is matched against the oldest accepted operation.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got %0h with no operation outstanding", out_word());
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", out_word(), {21'd0, mon_e.res});
        if (mon_e.lat) chk("latency", cyc - mon_e.acc, S);
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                      input logic sub, input logic [10:0] res, input bit lat);
    bit done = 0;
    bus.a = a;
    bus.b = b;
    bus.cin = cin;
    bus.sub = sub;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back('{res: res, acc: cyc, lat: lat});
        done = 1;
        break;
      end
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: in_ready stayed 0, expected 1");
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0};
    vecs[2] = '{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{8'h55, 8'h55, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'h01, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0, 1'b0};
    vecs[9] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0};

    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_fields", out_word(), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Each vector alone, checked for value and exact latency
    for (int i = 0; i < 10; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           {vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z}, 1'b1);
      wait_drain();
    end

    // Same table back-to-back
    for (int i = 0; i < 10; i++)
      send(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
           {vecs[i].s, vecs[i].co, vecs[i].ov, vecs[i].z}, 1'b1);
    wait_drain();

    // Random back-to-back stream
    for (int i = 0; i < 20; i++) begin
      logic [7:0] ra, rb;
      logic rc, rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rs = 1'($urandom);
      send(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'b1);
    end
    wait_drain();

    // Backpressure: four operations in flight, output blocked for six cycles
    bus.out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 1'b0, 11'({8'h03, 1'b0, 1'b0, 1'b0}), 1'b0);
    send(8'h40, 8'h40, 1'b0, 1'b0, 11'({8'h80, 1'b0, 1'b1, 1'b0}), 1'b0);
    send(8'h09, 8'h09, 1'b0, 1'b1, 11'({8'h00, 1'b1, 1'b0, 1'b1}), 1'b0);
    send(8'hF0, 8'h20, 1'b1, 1'b0, 11'({8'h11, 1'b1, 1'b0, 1'b0}), 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_hold", out_word(), {21'd0, 11'({8'h03, 1'b0, 1'b0, 1'b0})});
    end
    chk("stall_depth", exp_q.size(), 4);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    wait_drain();

    // Reset with three operations in flight
    send(8'h11, 8'h22, 1'b0, 1'b0, model(8'h11, 8'h22, 1'b0, 1'b0), 1'b1);
    send(8'h33, 8'h44, 1'b0, 1'b0, model(8'h33, 8'h44, 1'b0, 1'b0), 1'b1);
    send(8'h55, 8'h66, 1'b0, 1'b0, model(8'h55, 8'h66, 1'b0, 1'b0), 1'b1);
    @(posedge clk);
    #1;
    chk("pre_rst_out_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_fields", out_word(), 0);
    chk("mid_rst_in_ready", bus.in_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send(8'h7F, 8'h7F, 1'b1, 1'b0, 11'({8'hFF, 1'b0, 1'b1, 1'b0}), 1'b1);
    wait_drain();
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule
